// File: rtl/step_seq_pkg.sv
// rtl/step_seq_pkg.sv - shared types, defaults and tempo clamp for the step sequencer
package step_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_STEPS          = 12;
    localparam int DEF_STEPS_PER_BEAT = 4;
    localparam int DEF_BPM_MIN        = 40;
    localparam int DEF_BPM_MAX        = 240;
    localparam int IDX_W              = 4;

    function automatic logic [7:0] clamp_bpm(input logic [7:0] t,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
        if (t < lo) return lo;
        if (t > hi) return hi;
        return t;
    endfunction

endpackage

// File: rtl/step_generator_if.sv
// rtl/step_generator_if.sv - run control in, step outputs back
interface step_generator_if;
    import step_seq_pkg::*;

    logic             Play;
    logic [7:0]       Tempo;
    logic             Step;
    logic [IDX_W-1:0] StepIdx;
    logic             StepPulse;
    logic             LoopWrap;
    logic             Running;

    modport master (output Play, Tempo,
                    input  Step, StepIdx, StepPulse, LoopWrap, Running);

    modport slave  (input  Play, Tempo,
                    output Step, StepIdx, StepPulse, LoopWrap, Running);

endinterface

// File: rtl/tempo_accumulator.sv
// rtl/tempo_accumulator.sv - clamped tempo latch and phase accumulator
// Requests a Step toggle whenever the accumulated phase crosses a half step.
module tempo_accumulator
    import step_seq_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS_PER_BEAT = DEF_STEPS_PER_BEAT,
    parameter int BPM_MIN        = DEF_BPM_MIN,
    parameter int BPM_MAX        = DEF_BPM_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       load,
    input  logic [7:0] tempo,
    output logic       toggle
);

    localparam longint   HALF_L = longint'(CLK_HZ) * 30;
    localparam logic [32:0] HALF = 33'(HALF_L);

    if (HALF_L / longint'(BPM_MAX * STEPS_PER_BEAT) < 2) begin : g_rate_check
        $error("step high time below 2 cycles at BPM_MAX");
    end

    logic [31:0] acc_q;
    logic [7:0]  tempo_l_q;
    logic [31:0] inc;
    logic [32:0] sum;

    assign inc    = 32'(tempo_l_q) * 32'(STEPS_PER_BEAT);
    assign sum    = {1'b0, acc_q} + {1'b0, inc};
    assign toggle = (sum >= HALF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            tempo_l_q <= 8'(BPM_MIN);
        end else begin
            if (load) begin
                tempo_l_q <= clamp_bpm(tempo, 8'(BPM_MIN), 8'(BPM_MAX));
            end
            // The residual after subtracting HALF carries over, keeping the average rate exact.
            if (!advance) begin
                acc_q <= '0;
            end else if (toggle) begin
                acc_q <= sum[31:0] - HALF[31:0];
            end else begin
                acc_q <= sum[31:0];
            end
        end
    end

endmodule

// File: rtl/step_generator.sv
// rtl/step_generator.sv - run/idle FSM, Step square wave, step index and strobes
module step_generator
    import step_seq_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int STEPS          = DEF_STEPS,
    parameter int STEPS_PER_BEAT = DEF_STEPS_PER_BEAT,
    parameter int BPM_MIN        = DEF_BPM_MIN,
    parameter int BPM_MAX        = DEF_BPM_MAX
) (
    input logic             Clock,
    input logic             Reset,
    step_generator_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(STEPS - 1);

    state_t           state_q, state_d;
    logic             step_q, step_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pulse_q, pulse_d;
    logic             wrap_q, wrap_d;
    logic             run_q, run_d;
    logic             advance, load, toggle;

    assign advance = (state_q == RUN) && bus.Play;

    tempo_accumulator #(
        .CLK_HZ         (CLK_HZ),
        .STEPS_PER_BEAT (STEPS_PER_BEAT),
        .BPM_MIN        (BPM_MIN),
        .BPM_MAX        (BPM_MAX)
    ) u_acc (
        .clk     (Clock),
        .rst     (Reset),
        .advance (advance),
        .load    (load),
        .tempo   (bus.Tempo),
        .toggle  (toggle)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            step_q  <= 1'b0;
            idx_q   <= '0;
            pulse_q <= 1'b0;
            wrap_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            pulse_q <= pulse_d;
            wrap_q  <= wrap_d;
            run_q   <= run_d;
        end
    end

    // Dropping Play takes priority over a due toggle, so a stop never emits a strobe.
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        idx_d   = '0;
        pulse_d = 1'b0;
        wrap_d  = 1'b0;
        run_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Play) begin
                    state_d = RUN;
                    step_d  = 1'b1;
                    pulse_d = 1'b1;
                    run_d   = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (!bus.Play) begin
                    state_d = IDLE;
                end else begin
                    run_d  = 1'b1;
                    step_d = step_q;
                    idx_d  = idx_q;
                    if (toggle) begin
                        step_d = !step_q;
                        if (!step_q) begin
                            idx_d   = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
                            pulse_d = 1'b1;
                            wrap_d  = (idx_q == LAST);
                            load    = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Step      = step_q;
    assign bus.StepIdx   = idx_q;
    assign bus.StepPulse = pulse_q;
    assign bus.LoopWrap  = wrap_q;
    assign bus.Running   = run_q;

endmodule

// File: tb/tb_step_generator.sv
// tb/tb_step_generator.sv - self-checking bench for step_generator at CLK_HZ = 100
module tb_step_generator;
    import step_seq_pkg::*;

    localparam int HALF = 100 * 30;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    step_generator_if bus();

    step_generator #(.CLK_HZ(100)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] tempo;
        int         h1, l1, h2, l2;
    } vec_t;

    vec_t vt[9];

    int m_run, m_step, m_idx, m_pulse, m_wrap, m_inc, m_res, m_len, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.Step, bus.StepIdx, bus.StepPulse, bus.LoopWrap, bus.Running};
    endfunction

    function automatic int clampi(input int t);
        return (t < 40) ? 40 : ((t > 240) ? 240 : t);
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Duration-based reference: each half step lasts ceil((HALF - residual) / inc) cycles.
    task automatic model_edge(input bit play, input int tempo);
        m_pulse = 0;
        m_wrap  = 0;
        if (m_run == 0) begin
            if (play) begin
                m_run = 1; m_step = 1; m_idx = 0; m_pulse = 1;
                m_inc = clampi(tempo) * 4;
                m_res = 0;
                m_len = ceil_div(HALF, m_inc);
                m_cnt = m_len;
            end
        end else if (!play) begin
            m_run = 0; m_step = 0; m_idx = 0;
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_res  = m_res + m_len * m_inc - HALF;
                m_step = 1 - m_step;
                if (m_step == 1) begin
                    m_idx   = (m_idx + 1) % 12;
                    m_pulse = 1;
                    m_wrap  = (m_idx == 0) ? 1 : 0;
                    m_inc   = clampi(tempo) * 4;
                end
                m_len = ceil_div(HALF - m_res, m_inc);
                m_cnt = m_len;
            end
        end
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        bus.Play = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic start_play(input logic [7:0] t);
        bus.Tempo = t;
        bus.Play  = 1'b1;
        @(negedge Clock);
    endtask

    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (bus.Step === lvl && n < 200) begin
            n++;
            @(negedge Clock);
        end
    endtask

    task automatic cycles_to_pulse(output int n);
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (bus.StepPulse !== 1'b1 && n < 500);
    endtask

    initial begin
        int         n, h1, l1, h2, l2, pulses;
        bit         play_r;
        int         tempo_r;
        logic [7:0] e;

        vt[0] = '{8'd150,  5,  5,  5,  5};
        vt[1] = '{8'd0,   19, 19, 19, 18};
        vt[2] = '{8'd255,  4,  3,  3,  3};
        vt[3] = '{8'd240,  4,  3,  3,  3};
        vt[4] = '{8'd40,  19, 19, 19, 18};
        vt[5] = '{8'd75,  10, 10, 10, 10};
        vt[6] = '{8'd100,  8,  7,  8,  7};
        vt[7] = '{8'd37,  19, 19, 19, 18};
        vt[8] = '{8'd41,  19, 18, 18, 19};

        bus.Play  = 1'b0;
        bus.Tempo = 8'd150;
        #1 check("reset_async", 32'(outs()), 32'h0);
        do_reset();
        check("reset_state", 32'(outs()), 32'h0);

        foreach (vt[i]) begin
            do_reset();
            start_play(vt[i].tempo);
            check($sformatf("entry_%0d", vt[i].tempo), 32'(outs()), 32'h85);
            measure(1'b1, h1);
            measure(1'b0, l1);
            measure(1'b1, h2);
            measure(1'b0, l2);
            check($sformatf("h1_%0d", vt[i].tempo), 32'(h1), 32'(vt[i].h1));
            check($sformatf("l1_%0d", vt[i].tempo), 32'(l1), 32'(vt[i].l1));
            check($sformatf("h2_%0d", vt[i].tempo), 32'(h2), 32'(vt[i].h2));
            check($sformatf("l2_%0d", vt[i].tempo), 32'(l2), 32'(vt[i].l2));
        end

        // Loop wrap after a full 12-step loop at 150 BPM.
        do_reset();
        start_play(8'd150);
        n = 0;
        while (bus.LoopWrap !== 1'b1 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        check("wrap_latency", 32'(n), 32'd120);
        check("wrap_idx", 32'(bus.StepIdx), 32'd0);
        check("wrap_pulse", 32'(bus.StepPulse), 32'd1);
        @(negedge Clock);
        check("wrap_single", 32'(bus.LoopWrap), 32'd0);

        // Tempo change while Step is high affects only the following step.
        do_reset();
        start_play(8'd150);
        repeat (2) @(negedge Clock);
        bus.Tempo = 8'd75;
        cycles_to_pulse(n);
        check("tempo_chg_cur", 32'(n + 2), 32'd10);
        cycles_to_pulse(n);
        check("tempo_chg_next", 32'(n), 32'd20);

        // Stop on the third cycle of a high phase, then restart.
        do_reset();
        start_play(8'd150);
        cycles_to_pulse(n);
        cycles_to_pulse(n);
        check("stop_pre_idx", 32'(bus.StepIdx), 32'd2);
        repeat (2) @(negedge Clock);
        check("stop_pre_step", 32'(bus.Step), 32'd1);
        bus.Play = 1'b0;
        @(negedge Clock);
        check("stop_outs", 32'(outs()), 32'h0);
        bus.Play = 1'b1;
        @(negedge Clock);
        check("restart_outs", 32'(outs()), 32'h85);

        // Asynchronous reset mid-run, then restart with Play held.
        do_reset();
        start_play(8'd150);
        repeat (7) cycles_to_pulse(n);
        check("rst_pre_idx", 32'(bus.StepIdx), 32'd7);
        #2 Reset = 1'b1;
        #1 check("rst_immediate", 32'(outs()), 32'h0);
        @(negedge Clock);
        #3 Reset = 1'b0;
        @(negedge Clock);
        check("rst_restart", 32'(outs()), 32'h85);

        // Loop-counter style stop after 13 Step rising edges.
        do_reset();
        start_play(8'd150);
        pulses = 1;
        while (pulses < 13) begin
            cycles_to_pulse(n);
            pulses++;
            if (n >= 500) pulses = 13;
        end
        check("integ_wrap", 32'(bus.LoopWrap), 32'd1);
        check("integ_idx", 32'(bus.StepIdx), 32'd0);
        bus.Play = 1'b0;
        @(negedge Clock);
        check("integ_running", 32'(bus.Running), 32'd0);

        // Randomized run against the reference model.
        do_reset();
        m_run = 0; m_step = 0; m_idx = 0; m_pulse = 0; m_wrap = 0;
        tempo_r = 150;
        for (int k = 0; k < 4000; k++) begin
            play_r = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0:       tempo_r = 0;
                    1:       tempo_r = 255;
                    default: tempo_r = int'($urandom_range(0, 255));
                endcase
            end
            bus.Play  = play_r;
            bus.Tempo = 8'(tempo_r);
            @(negedge Clock);
            model_edge(play_r, tempo_r);
            e = {1'(m_step), 4'(m_idx), 1'(m_pulse), 1'(m_wrap), 1'(m_run)};
            check("random", 32'(outs()), 32'(e));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/step_generator.md
# step_generator

Tempo source for the step sequencer. While `Play` is high it produces the `Step` square wave that the loop counter and the audio generators count. It also produces a step index, a start-of-step strobe and a loop-wrap strobe. The step rate comes from a BPM value and a fixed steps-per-beat factor, using a phase accumulator so the average rate is exact.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock frequency in Hz.
- `STEPS`, 12: steps per loop.
- `STEPS_PER_BEAT`, 4: steps per quarter note.
- `BPM_MIN`, 40: lower tempo clamp.
- `BPM_MAX`, 240: upper tempo clamp.

Ports:
- `Clock`, in, 1: the single clock. One clock; reset is asynchronous and active-high.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Play`, in, 1: run enable, synchronous to `Clock`.
- `Tempo`, in, 8: BPM request.
- `Step`, out, 1: step square wave, high for the first half of each step.
- `StepIdx`, out, 4: current step, 0..STEPS-1.
- `StepPulse`, out, 1: one-cycle strobe coincident with each `Step` rising edge.
- `LoopWrap`, out, 1: one-cycle strobe when `StepIdx` wraps from STEPS-1 to 0.
- `Running`, out, 1: high in RUN.

## Operation
- Constants:
  - `HALF = CLK_HZ*30` (half-step threshold).
  - `inc = Tempo_l * STEPS_PER_BEAT`.
  - Accumulator is 32 bits, unsigned.
- Tempo clamp: `Tempo_l = min(max(Tempo, BPM_MIN), BPM_MAX)`. `Tempo = 0` maps to `BPM_MIN`.
- `Tempo_l` is latched on entry to RUN and at every `Step` rising edge only. Tempo changes never glitch a step in progress.
- IDLE state:
  - `Step = 0`, `StepIdx = 0`, accumulator 0, `Running = 0`, strobes 0.
  - `Play = 1` sampled → RUN.
- RUN, entry cycle:
  - `Step = 1`, `StepPulse = 1`, `StepIdx = 0`, `LoopWrap = 0`, accumulator 0, `Running = 1`.
- RUN, every following cycle:
  - If `acc + inc >= HALF`: `acc <= acc + inc - HALF` and `Step` toggles.
  - Otherwise: `acc <= acc + inc`.
- `Step` toggle 0→1:
  - `StepIdx <= (StepIdx == STEPS-1) ? 0 : StepIdx+1`.
  - `StepPulse = 1`.
  - `LoopWrap = 1` iff wrapping.
  - Re-latch `Tempo_l`.
- `Step` toggle 1→0: no strobes.
- RUN with `Play = 0` sampled → IDLE next cycle. All IDLE values apply on that edge, including `Step` forced low mid-step. There is no drain.
- `Play` falling and a toggle due on the same cycle: stop wins. No strobe is issued.
- `Reset` asserted at any time: immediate IDLE, all outputs 0, accumulator 0, `Tempo_l = BPM_MIN`.

## Timing
- Reset values: `Step`, `StepIdx`, `StepPulse`, `LoopWrap`, `Running` are all 0.
- Start latency: `Play` high before edge k → `Step`/`StepPulse`/`Running` high after edge k.
- Stop latency: `Play` low before edge k → IDLE outputs after edge k.
- Half-step length is `ceil((HALF - acc_residual) / inc)` cycles. The long-run average is exactly `HALF/inc`.
- `Step` high time must be at least 2 cycles for downstream edge detection. Elaboration check: `HALF / (BPM_MAX*STEPS_PER_BEAT) >= 2`.
- All outputs are registered. There are no combinational paths from input to output.
- `Play` re-asserted on the cycle after a stop restarts cleanly at `StepIdx` 0.

## Structure
- Shared package `step_seq_pkg` holds:
  - State enum {IDLE, RUN}.
  - Default `STEPS`, `STEPS_PER_BEAT`, `BPM_MIN`, `BPM_MAX`.
  - Step index width (4).
- Sub-module `tempo_accumulator` contains:
  - Clamp.
  - `Tempo_l` latch.
  - 32-bit accumulator with subtract-on-overflow.
  - Outputs a one-cycle `toggle` request.
- `step_generator` owns:
  - The FSM.
  - The `Step` register.
  - The index counter and strobes.

## Test plan
All scenarios use `CLK_HZ = 100`.

- Basic rate: `Tempo = 150`, `Play = 1` → `Step` 5 cycles high / 5 low. `StepPulse` every 10 cycles. `StepIdx` goes 0,1,…,11,0. `LoopWrap` is a single cycle on the 11→0 transition, 120 cycles after start.
- Clamp: `Tempo = 0` → effective 40 BPM (inc 160), average half-step 18.75 cycles, pattern 19,19,19,18 repeating. `Tempo = 255` → behaves as 240 BPM (inc 960).
- Tempo change mid-step: 150 → 75 while `Step` high → current step stays 10 cycles; the next step is 20 cycles.
- Stop mid-step: `Play` low on cycle 3 of a high phase → next edge `Step = 0`, `StepIdx = 0`, `Running = 0`, no `StepPulse`. Restart → `StepPulse` with `StepIdx = 0`.
- Reset mid-run: `Reset` pulse asynchronous to `Clock` during `StepIdx = 7` → all outputs 0 immediately. After release with `Play` still 1 → restarts at `StepIdx = 0` on the first edge.
- Integration: drive the loop counter with `Loops = 1` from this block's `Step` → its `Play` drops after exactly 13 `Step` rising edges. Feed that `Play` back to this block → `Running` low 1 cycle later.
